// File: rtl/gemm_pkg.sv
// Shared definitions for the GEMM result path: serializer state encoding
// and the helper that locates one matrix element in a flattened result word.
package gemm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_STREAM = 2'd2
  } ser_state_t;

  localparam int unsigned LAT_CNT_W = 8;

  // Lowest bit position of element k when elements of width dw are packed LSB-first.
  function automatic int elem_lo(input int k, input int dw);
    return k * dw;
  endfunction

endpackage

// File: rtl/matrix_result_serializer.sv
// Captures a flattened SIZE x SIZE result matrix LATENCY cycles after start and
// streams it out one element per valid/ready handshake in row-major order.
//
// state     | meaning
// ST_IDLE   | waiting for start; outputs quiet
// ST_WAIT   | counting down to the cycle the result word is valid
// ST_STREAM | presenting element k until accepted; last accept returns to idle
module matrix_result_serializer
  import gemm_pkg::*;
#(
  parameter int INPUT_DATA_WIDTH = 512,
  parameter int DATA_WIDTH       = 32,
  parameter int SIZE             = 4,
  parameter int LATENCY          = 3,
  localparam int RW              = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [INPUT_DATA_WIDTH-1:0] data_in,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_WIDTH-1:0]       m_data,
  output logic [RW-1:0]               m_row,
  output logic [RW-1:0]               m_col,
  output logic                        m_last,
  output logic                        busy,
  output logic                        done
);

  localparam int N  = SIZE * SIZE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = (INPUT_DATA_WIDTH > 1) ? $clog2(INPUT_DATA_WIDTH) : 1;

  ser_state_t                  state_q, state_d;
  logic [LAT_CNT_W-1:0]        cnt_q, cnt_d;
  logic [KW-1:0]               k_q, k_d;
  logic [INPUT_DATA_WIDTH-1:0] buf_q, buf_d;
  logic                        m_valid_q, m_valid_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic [BW-1:0]               lo;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    buf_d     = buf_q;
    m_valid_d = m_valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_WAIT;
          cnt_d   = LAT_CNT_W'(LATENCY - 1);
          busy_d  = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          buf_d     = data_in;
          state_d   = ST_STREAM;
          m_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_STREAM: begin
        if (m_ready) begin
          if (k_q == KW'(N - 1)) begin
            state_d   = ST_IDLE;
            k_d       = '0;
            m_valid_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        k_d       = '0;
        m_valid_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      k_q       <= '0;
      buf_q     <= '0;
      m_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      buf_q     <= buf_d;
      m_valid_q <= m_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Output mux reads only flops, so data/index stay stable while stalled.
  assign lo      = BW'(elem_lo(32'(k_q), DATA_WIDTH));
  assign m_data  = buf_q[lo +: DATA_WIDTH];
  assign m_row   = RW'(k_q / KW'(SIZE));
  assign m_col   = RW'(k_q % KW'(SIZE));
  assign m_last  = m_valid_q & (k_q == KW'(N - 1));
  assign m_valid = m_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
